// File: rtl/sha3_256_hls_mul_pkg.sv
// Shared constants for the pipelined multiplier.
//   MAX_STAGE  : deepest pipeline the multiplier supports.
//   full_width : width of an exact product of two operands.
package sha3_256_hls_mul_pkg;

  localparam int MAX_STAGE = 4;

  // An a-bit by b-bit product (signed or unsigned) always fits in a+b bits.
  function automatic int full_width(input int a, input int b);
    return a + b;
  endfunction

endpackage

// File: rtl/sha3_256_hls_mul_stage.sv
// One pipeline register of the multiplier: valid bit, data word and
// signed/unsigned mode bit, all cleared asynchronously by reset.
// Ports:
//   clk, reset          : clock, async active-high clear
//   en                  : load enable (pipeline advance)
//   valid_d/data_d/mode_d : next-stage contents
//   valid_q/data_q/mode_q : registered contents
module sha3_256_hls_mul_stage
  import sha3_256_hls_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  input  logic         mode_d,
  output logic         valid_q,
  output logic [W-1:0] data_q,
  output logic         mode_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: rtl/sha3_256_hls_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control.
// The product is formed combinationally ahead of stage 0; the remaining
// stages only carry it. The last stage is the output register.
// Ports:
//   clk, reset        : clock, async active-high reset
//   ce                : global clock enable, low freezes everything
//   in_valid/in_ready : operand handshake
//   din0, din1        : operands A and B
//   is_signed         : 1 = two's complement, 0 = unsigned (per transaction)
//   out_valid/out_ready : result handshake
//   dout              : low dout_WIDTH bits of the product
//   ovf               : set when dout does not represent the full product
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The whole pipe moves together on "advance" (ce high and the
// output register empty or being consumed); in_ready is advance itself, so
// a consume and a new acceptance can share one cycle. Without advance every
// stage, dout, ovf and out_valid hold. Empty slots flow as invalid stages.
module sha3_256_hls_mul_pipe
  import sha3_256_hls_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,   // 1..MAX_STAGE
  parameter int din0_WIDTH = 29,
  parameter int din1_WIDTH = 31,
  parameter int dout_WIDTH = 59   // 2..din0_WIDTH+din1_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int FW = full_width(din0_WIDTH, din1_WIDTH);

  if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE) begin : g_bad_num_stage
    $error("sha3_256_hls_mul_pipe %0d: NUM_STAGE out of range", ID);
  end

  logic          advance;
  logic [FW-1:0] a_ext;
  logic [FW-1:0] b_ext;
  logic [FW-1:0] prod;

  logic          stage_valid [NUM_STAGE];
  logic [FW-1:0] stage_data  [NUM_STAGE];
  logic          stage_mode  [NUM_STAGE];

  assign advance  = ce && (!out_valid || out_ready);
  assign in_ready = advance;

  // Extending both operands to FW bits and keeping the low FW bits of the
  // product gives the exact result in either mode, since it always fits.
  always_comb begin
    a_ext = {{din1_WIDTH{is_signed & din0[din0_WIDTH-1]}}, din0};
    b_ext = {{din0_WIDTH{is_signed & din1[din1_WIDTH-1]}}, din1};
    prod  = a_ext * b_ext;
  end

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    logic          valid_d;
    logic [FW-1:0] data_d;
    logic          mode_d;

    if (i == 0) begin : g_head
      assign valid_d = in_valid;
      assign data_d  = prod;
      assign mode_d  = is_signed;
    end else begin : g_body
      assign valid_d = stage_valid[i-1];
      assign data_d  = stage_data[i-1];
      assign mode_d  = stage_mode[i-1];
    end

    sha3_256_hls_mul_stage #(
      .W (FW)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (advance),
      .valid_d (valid_d),
      .data_d  (data_d),
      .mode_d  (mode_d),
      .valid_q (stage_valid[i]),
      .data_q  (stage_data[i]),
      .mode_q  (stage_mode[i])
    );
  end

  assign out_valid = stage_valid[NUM_STAGE-1];
  assign dout      = stage_data[NUM_STAGE-1][dout_WIDTH-1:0];

  // Overflow: the discarded upper bits must equal the extension of dout
  // (copies of its top bit when signed, zeros when unsigned). Derived from
  // the output register, so it is 0 after reset and holds during stalls.
  if (dout_WIDTH < FW) begin : g_ovf
    logic [FW-dout_WIDTH-1:0] upper;
    logic [FW-dout_WIDTH-1:0] ext;
    always_comb begin
      upper = stage_data[NUM_STAGE-1][FW-1:dout_WIDTH];
      ext   = {(FW-dout_WIDTH){stage_mode[NUM_STAGE-1] &
                               stage_data[NUM_STAGE-1][dout_WIDTH-1]}};
      ovf   = (upper != ext);
    end
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

endmodule

// File: tb/tb_sha3_256_hls_mul_pipe.sv
module tb_sha3_256_hls_mul_pipe;

  localparam int NS = 2;
  localparam int W0 = 29;
  localparam int W1 = 31;
  localparam int DW = 8;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          in_valid;
  logic          in_ready;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          ovf;

  always #5 clk = ~clk;

  sha3_256_hls_mul_pipe #(
    .ID         (1),
    .NUM_STAGE  (NS),
    .din0_WIDTH (W0),
    .din1_WIDTH (W1),
    .dout_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf)
  );

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  int            n_in = 0;
  int            n_out = 0;
  int            n_drop = 0;
  logic [DW:0]   exp_q[$];   // {ovf, dout}
  logic [DW:0]   mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a result is consumed on an edge with ce, out_valid, out_ready.
  always @(negedge clk) begin
    if (!reset && ce && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected no result", {ovf, dout});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {ovf, dout}, mon_exp);
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int a, input int b, input logic s, input logic [DW:0] e);
    int n;
    n = 0;
    din0      = a[W0-1:0];
    din1      = b[W1-1:0];
    is_signed = s;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid is seen (bounded).
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic sync_idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors (hand-computed, DW=8) ----------------
  localparam int NV = 15;
  int          va [NV] = '{ -3,  16,  -8,  15,  15,  -1, 536870911, 536870911,
                             -3,   8, 127,   0,  -1,   3, -16};
  int          vb [NV] = '{  7,  16,  16,  17,  17,  -1, 1, 1,
                            43,  16,   1, 12345, -1,  -5,   8};
  logic        vs [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [DW:0] ve [NV] = '{9'h0EB, 9'h100, 9'h080, 9'h0FF, 9'h1FF, 9'h001, 9'h1FF, 9'h0FF,
                           9'h17F, 9'h180, 9'h07F, 9'h000, 9'h101, 9'h0F1, 9'h080};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    is_signed = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sync_idle(1);

    // Basic latency: 3*5 unsigned
    send(3, 5, 1'b0, 9'h00F);
    wait_out(n);
    check("latency_basic", n, NS);
    sync_idle(3);

    // Directed table, back to back, out_ready high
    for (int i = 0; i < NV; i++) send(va[i], vb[i], vs[i], ve[i]);
    sync_idle(5);
    check("table_drained", exp_q.size(), 0);

    // Back-pressure: 4 back-to-back, consumer stalls 3 cycles on first result
    fork
      begin
        for (int i = 0; i < 4; i++) send(2*i+1, 2*i+2, 1'b0, 9'((2*i+1)*(2*i+2)));
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
          @(posedge clk);
          #1;
          k++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_dout", dout, 2);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    sync_idle(6);
    check("stall_drained", exp_q.size(), 0);

    // ce low for 2 cycles right after acceptance: latency grows by 2
    send(9, 9, 1'b0, 9'h051);
    ce = 1'b0;
    @(negedge clk);
    check("ce_in_ready", in_ready, 0);
    check("ce_hold_v0", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("ce_hold_v1", out_valid, 0);
    @(posedge clk);
    #1;
    ce = 1'b1;
    wait_out(n);
    check("ce_latency", n + 2, NS + 2);
    sync_idle(3);

    // ce low while a result is held: frozen, then delivered exactly once
    out_ready = 1'b0;
    send(-5, 5, 1'b1, 9'h0E7);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ce        = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("freeze_valid", out_valid, 1);
      check("freeze_dout", {ovf, dout}, 9'h0E7);
      check("freeze_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("no_duplicate", out_valid, 0);
    sync_idle(2);

    // Reset between edges with two transactions in flight
    send(10, 10, 1'b0, 9'h064);
    send(20, 3, 1'b0, 9'h03C);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_ovf", ovf, 0);
    n_drop = n_drop + exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(6, 7, 1'b0, 9'h02A);
    wait_out(n);
    check("post_rst_latency", n, NS);
    sync_idle(4);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_count", n_out, n_in - n_drop);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
